pic_in_service_rotating: RTL and testbench

- Parametrised in-service register (ISR) for the PIC. Tracks which of NUM_IRQ interrupt channels are currently being serviced.
- Sets an ISR bit on interrupt acknowledge and clears bits on specific or non-specific EOI.
- Supports fixed and rotating priority, with a programmable lowest-priority channel.
- Sits between the priority resolver and the control logic. Its highest-in-service output feeds back to the resolver for nested-priority masking.

---
 rtl/pic_pkg.sv | 40 ++++
 rtl/pic_rotating_priority_encoder.sv | 42 ++++
 rtl/pic_in_service_rotating.sv | 172 +++++++++++++++++
 tb/tb_pic_in_service_rotating.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types, constants and helpers for the PIC blocks
//
// Purpose: common definitions for the PIC in-service register, priority
// resolver and control logic.
//   PIC_MAX_IRQ    largest supported channel count
//   PIC_MAX_ID_W   channel index width at PIC_MAX_IRQ
//   isr_id_w(n)    index width for n channels, never below 1
//   id_in_range    true when a channel index addresses a real channel
//   pic_isr_cmd_t  bundled acknowledge / EOI / priority command fields
package pic_pkg;

  localparam int PIC_MAX_IRQ = 32;

  function automatic int isr_id_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int PIC_MAX_ID_W = isr_id_w(PIC_MAX_IRQ);

  // Compared as int so narrow index ports never produce constant-result
  // comparisons when NUM_IRQ is a power of two.
  function automatic logic id_in_range(input int id, input int n);
    return id < n;
  endfunction

  typedef struct packed {
    logic                    acknowledge;
    logic [PIC_MAX_ID_W-1:0] ack_id;
    logic                    eoi_nonspecific;
    logic                    eoi_specific;
    logic [PIC_MAX_ID_W-1:0] eoi_id;
    logic                    rotate_on_eoi;
    logic                    set_priority;
    logic [PIC_MAX_ID_W-1:0] priority_id;
    logic                    auto_eoi;
  } pic_isr_cmd_t;

endpackage

// File: rtl/pic_rotating_priority_encoder.sv
// rtl/pic_rotating_priority_encoder.sv - rotating-priority first-set finder
//
// Purpose: combinational search for the highest-priority set bit when
// channel (lowest_priority+1) mod NUM_IRQ is highest and priority falls with
// increasing index, wrapping, so lowest_priority itself is last.
// Ports:
//   vector           in  NUM_IRQ  request / in-service bits to search
//   lowest_priority  in  ID_W     channel currently holding lowest priority
//   found            out 1        any bit of vector set
//   index            out ID_W     winning channel; 0 when found=0
module pic_rotating_priority_encoder
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = isr_id_w(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] vector,
  input  logic [ID_W-1:0]    lowest_priority,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  assign found = |vector;

  // Each channel gets a rank (0 = highest) relative to lowest_priority;
  // the set channel with the smallest rank wins.
  always_comb begin
    int best_rank;
    int rank;
    best_rank = NUM_IRQ;
    rank      = 0;
    index     = '0;
    for (int j = 0; j < NUM_IRQ; j++) begin
      rank = (j - int'(lowest_priority) - 1 + 2 * NUM_IRQ) % NUM_IRQ;
      if (vector[j] && (rank < best_rank)) begin
        best_rank = rank;
        index     = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/pic_in_service_rotating.sv
// rtl/pic_in_service_rotating.sv - PIC in-service register with rotating priority
//
// Purpose: tracks which interrupt channels are in service. Acknowledge sets a
// bit, specific / non-specific EOI clears bits, and the lowest-priority
// channel is programmable or rotates to the channel cleared by an EOI.
// Optional feature macro: PIC_ISR_AUTO_EOI_EN (auto-EOI mode driven by auto_eoi).
// Ports:
//   clock                in  1        rising-edge clock
//   reset                in  1        synchronous active-high reset
//   acknowledge          in  1        pulse: set ISR[ack_id]
//   ack_id               in  ID_W     acknowledged channel
//   eoi_nonspecific      in  1        pulse: clear highest in-service bit
//   eoi_specific         in  1        pulse: clear ISR[eoi_id]
//   eoi_id               in  ID_W     specific EOI target
//   rotate_on_eoi        in  1        cleared channel becomes lowest priority
//   set_priority         in  1        pulse: lowest_priority <= priority_id
//   priority_id          in  ID_W     new lowest-priority channel
//   auto_eoi             in  1        auto-EOI mode select
//   in_service_interrupt out NUM_IRQ  ISR contents
//   isr_any              out 1        any ISR bit set
//   highest_in_service   out ID_W     highest-priority set ISR bit (0 if none)
//   lowest_priority      out ID_W     current lowest-priority channel
module pic_in_service_rotating
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = isr_id_w(NUM_IRQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               acknowledge,
  input  logic [ID_W-1:0]    ack_id,
  input  logic               eoi_nonspecific,
  input  logic               eoi_specific,
  input  logic [ID_W-1:0]    eoi_id,
  input  logic               rotate_on_eoi,
  input  logic               set_priority,
  input  logic [ID_W-1:0]    priority_id,
  input  logic               auto_eoi,
  output logic [NUM_IRQ-1:0] in_service_interrupt,
  output logic               isr_any,
  output logic [ID_W-1:0]    highest_in_service,
  output logic               lowest_priority_unused_guard,
  output logic [ID_W-1:0]    lowest_priority
);

  typedef logic [NUM_IRQ-1:0] vec_t;

  pic_isr_cmd_t     cmd;
  vec_t             isr_q;
  vec_t             isr_d;
  logic [ID_W-1:0]  lp_q;
  logic [ID_W-1:0]  lp_d;
  logic             enc_found;
  logic [ID_W-1:0]  enc_index;
  logic             ack_ok;
  logic             spec_ok;
  logic             set_ok;
  logic             ns_ok;
  logic             auto_clr;
  logic [ID_W-1:0]  auto_id;

  always_comb begin
    cmd                 = '0;
    cmd.acknowledge     = acknowledge;
    cmd.ack_id          = PIC_MAX_ID_W'(ack_id);
    cmd.eoi_nonspecific = eoi_nonspecific;
    cmd.eoi_specific    = eoi_specific;
    cmd.eoi_id          = PIC_MAX_ID_W'(eoi_id);
    cmd.rotate_on_eoi   = rotate_on_eoi;
    cmd.set_priority    = set_priority;
    cmd.priority_id     = PIC_MAX_ID_W'(priority_id);
    cmd.auto_eoi        = auto_eoi;
  end

  // Out-of-range ids drop the whole command, rotation included.
  assign ack_ok  = cmd.acknowledge  && id_in_range(int'(cmd.ack_id), NUM_IRQ);
  assign spec_ok = cmd.eoi_specific && id_in_range(int'(cmd.eoi_id), NUM_IRQ);
  assign set_ok  = cmd.set_priority && id_in_range(int'(cmd.priority_id), NUM_IRQ);

  pic_rotating_priority_encoder #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_encoder (
    .vector          (isr_q),
    .lowest_priority (lp_q),
    .found           (enc_found),
    .index           (enc_index)
  );

  // Non-specific EOI acts only when something is in service (old ISR).
  assign ns_ok = cmd.eoi_nonspecific && enc_found;

`ifdef PIC_ISR_AUTO_EOI_EN
  logic            auto_pend_q;
  logic [ID_W-1:0] auto_id_q;

  // An auto-EOI acknowledge is remembered for one cycle and cleared on the
  // following edge; a re-acknowledge in that cycle re-sets the bit after
  // the clear and arms the next auto-clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      auto_pend_q <= 1'b0;
      auto_id_q   <= '0;
    end else begin
      auto_pend_q <= ack_ok && cmd.auto_eoi;
      if (ack_ok && cmd.auto_eoi) begin
        auto_id_q <= ID_W'(cmd.ack_id);
      end
    end
  end

  assign auto_clr = auto_pend_q;
  assign auto_id  = auto_id_q;
`else
  logic unused_auto_eoi;
  assign unused_auto_eoi = cmd.auto_eoi;
  assign auto_clr        = 1'b0;
  assign auto_id         = '0;
`endif

  // Clears are evaluated on the old ISR, then the acknowledge set wins.
  always_comb begin
    isr_d = isr_q;
    if (ns_ok) begin
      isr_d = isr_d & ~(vec_t'(1) << enc_index);
    end
    if (spec_ok) begin
      isr_d = isr_d & ~(vec_t'(1) << ID_W'(cmd.eoi_id));
    end
    if (auto_clr) begin
      isr_d = isr_d & ~(vec_t'(1) << auto_id);
    end
    if (ack_ok) begin
      isr_d = isr_d | (vec_t'(1) << ID_W'(cmd.ack_id));
    end
  end

  // Explicit priority load beats rotation; a specific EOI beats a
  // non-specific one, and explicit EOIs beat the auto-clear.
  always_comb begin
    lp_d = lp_q;
    if (set_ok) begin
      lp_d = ID_W'(cmd.priority_id);
    end else if (cmd.rotate_on_eoi) begin
      if (spec_ok) begin
        lp_d = ID_W'(cmd.eoi_id);
      end else if (ns_ok) begin
        lp_d = enc_index;
      end else if (auto_clr) begin
        lp_d = auto_id;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      isr_q <= '0;
      lp_q  <= ID_W'(NUM_IRQ - 1);
    end else begin
      isr_q <= isr_d;
      lp_q  <= lp_d;
    end
  end

  assign in_service_interrupt         = isr_q;
  assign isr_any                      = |isr_q;
  assign highest_in_service           = enc_index;
  assign lowest_priority              = lp_q;
  assign lowest_priority_unused_guard = 1'b0;

endmodule

// File: tb/tb_pic_in_service_rotating.sv
// tb/tb_pic_in_service_rotating.sv - directed self-checking bench for pic_in_service_rotating
module tb_pic_in_service_rotating;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic acknowledge = 1'b0;
  logic eoi_nonspecific = 1'b0;
  logic eoi_specific = 1'b0;
  logic rotate_on_eoi = 1'b0;
  logic set_priority = 1'b0;
  logic auto_eoi = 1'b0;

  logic [2:0] a_ack_id = '0;
  logic [2:0] a_eoi_id = '0;
  logic [2:0] a_pri_id = '0;
  logic [3:0] b_ack_id = '0;
  logic [3:0] b_eoi_id = '0;
  logic [3:0] b_pri_id = '0;

  logic [7:0]  isr8;
  logic        any8;
  logic [2:0]  hi8;
  logic [2:0]  lp8;
  logic        g8;
  logic [15:0] isr16;
  logic        any16;
  logic [3:0]  hi16;
  logic [3:0]  lp16;
  logic        g16;
  logic [11:0] isr12;
  logic        any12;
  logic [3:0]  hi12;
  logic [3:0]  lp12;
  logic        g12;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  pic_in_service_rotating #(.NUM_IRQ(8)) dut8 (
    .clock(clock), .reset(reset), .acknowledge(acknowledge), .ack_id(a_ack_id),
    .eoi_nonspecific(eoi_nonspecific), .eoi_specific(eoi_specific), .eoi_id(a_eoi_id),
    .rotate_on_eoi(rotate_on_eoi), .set_priority(set_priority), .priority_id(a_pri_id),
    .auto_eoi(auto_eoi), .in_service_interrupt(isr8), .isr_any(any8),
    .highest_in_service(hi8), .lowest_priority_unused_guard(g8), .lowest_priority(lp8)
  );

  pic_in_service_rotating #(.NUM_IRQ(16)) dut16 (
    .clock(clock), .reset(reset), .acknowledge(acknowledge), .ack_id(b_ack_id),
    .eoi_nonspecific(eoi_nonspecific), .eoi_specific(eoi_specific), .eoi_id(b_eoi_id),
    .rotate_on_eoi(rotate_on_eoi), .set_priority(set_priority), .priority_id(b_pri_id),
    .auto_eoi(auto_eoi), .in_service_interrupt(isr16), .isr_any(any16),
    .highest_in_service(hi16), .lowest_priority_unused_guard(g16), .lowest_priority(lp16)
  );

  pic_in_service_rotating #(.NUM_IRQ(12)) dut12 (
    .clock(clock), .reset(reset), .acknowledge(acknowledge), .ack_id(b_ack_id),
    .eoi_nonspecific(eoi_nonspecific), .eoi_specific(eoi_specific), .eoi_id(b_eoi_id),
    .rotate_on_eoi(rotate_on_eoi), .set_priority(set_priority), .priority_id(b_pri_id),
    .auto_eoi(auto_eoi), .in_service_interrupt(isr12), .isr_any(any12),
    .highest_in_service(hi12), .lowest_priority_unused_guard(g12), .lowest_priority(lp12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    reset           = 1'b0;
    acknowledge     = 1'b0;
    eoi_nonspecific = 1'b0;
    eoi_specific    = 1'b0;
    rotate_on_eoi   = 1'b0;
    set_priority    = 1'b0;
    auto_eoi        = 1'b0;
  endtask

  task automatic ack8(input logic [2:0] id);
    acknowledge = 1'b1; a_ack_id = id; tick();
  endtask

  task automatic eoi8(input logic [2:0] id);
    eoi_specific = 1'b1; a_eoi_id = id; tick();
  endtask

  initial begin
    reset = 1'b1; tick();
    check("rst_isr", 32'(isr8), 32'h00);
    check("rst_any", 32'(any8), 32'd0);
    check("rst_hi", 32'(hi8), 32'd0);
    check("rst_lp", 32'(lp8), 32'd7);

    ack8(3'd3); ack8(3'd1);
    check("nest_isr", 32'(isr8), 32'h0A);
    check("nest_hi", 32'(hi8), 32'd1);
    check("nest_any", 32'(any8), 32'd1);
    eoi_nonspecific = 1'b1; tick();
    check("ns_isr", 32'(isr8), 32'h08);
    check("ns_hi", 32'(hi8), 32'd3);

    eoi8(3'd3); ack8(3'd7); ack8(3'd0);
    check("fix_isr", 32'(isr8), 32'h81);
    check("fix_hi", 32'(hi8), 32'd0);
    eoi8(3'd7);
    check("sp7_isr", 32'(isr8), 32'h01);
    check("sp7_lp", 32'(lp8), 32'd7);
    eoi8(3'd5);
    check("sp_empty", 32'(isr8), 32'h01);

    eoi8(3'd0); ack8(3'd2); ack8(3'd5);
    set_priority = 1'b1; a_pri_id = 3'd4; tick();
    check("setp_lp", 32'(lp8), 32'd4);
    check("setp_isr", 32'(isr8), 32'h24);
    check("setp_hi", 32'(hi8), 32'd5);
    eoi_nonspecific = 1'b1; rotate_on_eoi = 1'b1; tick();
    check("rot_isr", 32'(isr8), 32'h04);
    check("rot_lp", 32'(lp8), 32'd5);
    check("rot_hi", 32'(hi8), 32'd2);

    acknowledge = 1'b1; a_ack_id = 3'd2; eoi_specific = 1'b1; a_eoi_id = 3'd2; tick();
    check("ackeoi_isr", 32'(isr8), 32'h04);
    check("ackeoi_lp", 32'(lp8), 32'd5);

    reset = 1'b1; acknowledge = 1'b1; a_ack_id = 3'd6; tick();
    check("rstack_isr", 32'(isr8), 32'h00);
    check("rstack_lp", 32'(lp8), 32'd7);

    eoi_nonspecific = 1'b1; rotate_on_eoi = 1'b1; tick();
    check("ns_empty_lp", 32'(lp8), 32'd7);
    check("ns_empty_isr", 32'(isr8), 32'h00);

    ack8(3'd1);
    eoi_specific = 1'b1; a_eoi_id = 3'd1; rotate_on_eoi = 1'b1;
    set_priority = 1'b1; a_pri_id = 3'd3; tick();
    check("setp_wins_lp", 32'(lp8), 32'd3);
    check("setp_wins_isr", 32'(isr8), 32'h00);

    reset = 1'b1; tick();
    acknowledge = 1'b1; a_ack_id = 3'd6; auto_eoi = 1'b1; rotate_on_eoi = 1'b1; tick();
    check("aeoi_set", 32'(isr8), 32'h40);
    check("aeoi_set_lp", 32'(lp8), 32'd7);
    auto_eoi = 1'b1; rotate_on_eoi = 1'b1; tick();
`ifdef PIC_ISR_AUTO_EOI_EN
    check("aeoi_clr", 32'(isr8), 32'h00);
    check("aeoi_lp", 32'(lp8), 32'd6);
`else
    check("aeoi_hold", 32'(isr8), 32'h40);
    check("aeoi_lp", 32'(lp8), 32'd7);
`endif

    reset = 1'b1; tick();
    check("rst16_lp", 32'(lp16), 32'd15);
    check("rst12_lp", 32'(lp12), 32'd11);
    acknowledge = 1'b1; b_ack_id = 4'd15; tick();
    acknowledge = 1'b1; b_ack_id = 4'd0; tick();
    set_priority = 1'b1; b_pri_id = 4'd0; tick();
    check("w16_isr", 32'(isr16), 32'h8001);
    check("w16_hi", 32'(hi16), 32'd15);
    check("w16_lp", 32'(lp16), 32'd0);
    check("w12_isr", 32'(isr12), 32'h001);
    check("w12_lp", 32'(lp12), 32'd0);
    acknowledge = 1'b1; b_ack_id = 4'd13; tick();
    check("oor_ack12", 32'(isr12), 32'h001);
    check("ack13_16", 32'(isr16), 32'hA001);
    set_priority = 1'b1; b_pri_id = 4'd13; tick();
    check("oor_pri12", 32'(lp12), 32'd0);
    check("pri16", 32'(lp16), 32'd13);
    eoi_specific = 1'b1; b_eoi_id = 4'd14; rotate_on_eoi = 1'b1; tick();
    check("oor_eoi12_isr", 32'(isr12), 32'h001);
    check("oor_eoi12_lp", 32'(lp12), 32'd0);
    check("eoi16_lp", 32'(lp16), 32'd14);
    check("eoi16_isr", 32'(isr16), 32'hA001);
    check("any12", 32'(any12), 32'd1);
    check("hi12", 32'(hi12), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
